alu_mul_seq: RTL
================

// Module: alu_mul_seq
// PURPOSE
//  Sequencer that borrows the 8-bit ALU to do an unsigned 8x8 -> 16 multiply by shift-and-add.
//  Uses two ALU ops: ADD (op=0011) and rotate-right-through-carry (right=1, op=1111).
//  Top level muxes alu_* onto the ALU while alu_sel=1; the CPU owns the ALU otherwise.
//  Start/busy/done handshake toward the microcode / control unit.
// PARAMETERS
//  SKIP_ZERO  1  1: skip the ADD pair when multiplier LSB=0; 0: always ADD (BI=0), fixed latency
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  rdy        in   1   global RDY; 0 freezes the FSM and all internal registers
//  start      in   1   request; sampled only in IDLE with rdy=1
//  a          in   8   multiplicand, captured on start
//  b          in   8   multiplier, captured on start
//  busy       out  1   1 from the cycle after start acceptance until the DONE cycle (inclusive)
//  done       out  1   1-cycle pulse in the DONE state
//  product    out  16  {P,Q}; valid from done, held until the next start is accepted
//  alu_sel    out  1   =busy; selects controller drive onto the ALU
//  alu_op     out  4   0011 in ADD_ISS, 1111 in SHF_ISS, 0000 otherwise
//  alu_right  out  1   1 only in SHF_ISS
//  alu_ai     out  8   P register
//  alu_bi     out  8   ADD_ISS: Q[0]?M:8'h00; otherwise 8'h00
//  alu_ci     out  1   ADD_ISS: 0; SHF_ISS: C; otherwise 0
//  alu_bcd    out  1   constant 0
//  alu_rdy    out  1   rdy & (state is ADD_ISS or SHF_ISS)
//  alu_out    in   8   ALU registered result (valid the cycle after issue)
//  alu_co     in   1   ALU registered carry out
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, M=P=Q=0, C=0, cnt=0; every output 0 (product=16'h0000).
//  All transitions/register updates happen only when rdy=1; rdy=0 holds state; alu_rdy drops to 0.
//  States: IDLE, ADD_ISS, ADD_CAP, SHF_ISS, SHF_CAP, DONE.
//   IDLE:    start=1 -> M<=a, Q<=b, P<=0, C<=0, cnt<=8; next = NXT(b[0]).
//   NXT(q0): (q0 | ~SKIP_ZERO) ? ADD_ISS : SHF_ISS.
//   ADD_ISS: drive ADD (AI=P, BI=Q[0]?M:0, CI=0); -> ADD_CAP.
//   ADD_CAP: P<=alu_out, C<=alu_co; -> SHF_ISS.
//   SHF_ISS: drive shift (AI=P, CI=C); ALU returns {C,P[7:1]}, CO=P[0]; -> SHF_CAP.
//   SHF_CAP: P<=alu_out, Q<={alu_co,Q[7:1]}, C<=0, cnt<=cnt-1;
//            cnt==1 -> DONE, else -> NXT(Q[1]) (the new LSB).
//   DONE:    done=1, busy=1; -> IDLE.
//  Result: product = a*b exactly, no overflow (9-bit P+C intermediate, 16-bit result).
//  Latency: N = 16 + 2*popcount(b) ISS/CAP cycles (SKIP_ZERO=1); N=32 (SKIP_ZERO=0).
//   done is high in cycle N+1 after the start-acceptance edge, with no rdy=0 cycles.
//   Each rdy=0 cycle adds exactly 1 cycle.
//  start while busy: ignored, no effect on the operation in flight.
//  start in the DONE cycle: ignored; accepted in IDLE on the following cycle.
//  Back-to-back: minimum 1 IDLE cycle between operations.
//  rdy=0 between ISS and CAP: the ALU also holds (RDY=0), so alu_out stays valid at capture.
//  reset_n low mid-operation: immediate abort to reset state; done is never pulsed.
//  product is updated only by P/Q registers; it is not guaranteed meaningful while busy.
// TESTING
//  1. a=0x0D, b=0x0B, SKIP_ZERO=1 -> product=0x008F; done at cycle 23 (16+2*3+1).
//  2. a=0xFF, b=0xFF -> product=0xFE01; done at cycle 33; ADD carry must propagate via C.
//  3. a=0xA5, b=0x00 -> product=0x0000; done at cycle 17; alu_op never 0011.
//  4. SKIP_ZERO=0, a=0x12, b=0x00 -> product=0x0000; done at cycle 33.
//  5. a=0x0D, b=0x0B, rdy=0 for 5 cycles mid-op -> product=0x008F, done at 28; start pulses while busy ignored.
//  6. reset_n low at cycle 10 of a=0xFF*0xFF -> all outputs 0 at once, no done; new start 0x02*0x03 -> 0x0006.

Source files
------------

// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if: start/busy/done handshake plus the controller-side ALU bus
//   master: the multiply sequencer (drives ALU operands, reports busy/done/product)
//   slave : the control unit and the ALU (drive start/a/b, return alu_out/alu_co)
interface alu_mul_seq_if;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        alu_sel;
  logic [3:0]  alu_op;
  logic        alu_right;
  logic [7:0]  alu_ai;
  logic [7:0]  alu_bi;
  logic        alu_ci;
  logic        alu_bcd;
  logic        alu_rdy;
  logic [7:0]  alu_out;
  logic        alu_co;
  modport master (
    input  start, a, b, alu_out, alu_co,
    output busy, done, product, alu_sel, alu_op, alu_right, alu_ai, alu_bi, alu_ci, alu_bcd, alu_rdy
  );
  modport slave (
    output start, a, b, alu_out, alu_co,
    input  busy, done, product, alu_sel, alu_op, alu_right, alu_ai, alu_bi, alu_ci, alu_bcd, alu_rdy
  );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned 8x8->16 shift-and-add multiply sequenced through the shared 8-bit ALU
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   rdy     : global ready, 0 freezes every register
//   bus     : start/a/b in, busy/done/product out, alu_* drive toward the ALU, alu_out/alu_co back
module alu_mul_seq #(
  parameter bit SKIP_ZERO = 1'b1
) (
  input logic           clk,
  input logic           reset_n,
  input logic           rdy,
  alu_mul_seq_if.master bus
);
  typedef enum logic [2:0] {IDLE, ADD_ISS, ADD_CAP, SHF_ISS, SHF_CAP, DONE} state_t;
  state_t     state, state_n;
  logic [7:0] m, m_n, p, p_n, q, q_n;
  logic       c, c_n;
  logic [3:0] cnt, cnt_n;
  logic       busy, add_iss, shf_iss;
  // With SKIP_ZERO clear every bit gets an ADD (BI=0 on zero bits) for fixed latency.
  function automatic state_t nxt(input logic q0);
    return (q0 | ~SKIP_ZERO) ? ADD_ISS : SHF_ISS;
  endfunction
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      m     <= '0;
      p     <= '0;
      q     <= '0;
      c     <= 1'b0;
      cnt   <= '0;
    end else if (rdy) begin
      state <= state_n;
      m     <= m_n;
      p     <= p_n;
      q     <= q_n;
      c     <= c_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n = state;
    m_n     = m;
    p_n     = p;
    q_n     = q;
    c_n     = c;
    cnt_n   = cnt;
    case (state)
      IDLE: if (bus.start) begin
        m_n     = bus.a;
        q_n     = bus.b;
        p_n     = '0;
        c_n     = 1'b0;
        cnt_n   = 4'd8;
        state_n = nxt(bus.b[0]);
      end
      ADD_ISS: state_n = ADD_CAP;
      // The ADD carry becomes the ninth bit of P and re-enters through the rotate.
      ADD_CAP: begin
        p_n     = bus.alu_out;
        c_n     = bus.alu_co;
        state_n = SHF_ISS;
      end
      SHF_ISS: state_n = SHF_CAP;
      // The bit rotated out of P moves into the top of Q; Q[1] is the next multiplier bit.
      SHF_CAP: begin
        p_n     = bus.alu_out;
        q_n     = {bus.alu_co, q[7:1]};
        c_n     = 1'b0;
        cnt_n   = cnt - 4'd1;
        state_n = (cnt == 4'd1) ? DONE : nxt(q[1]);
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign busy          = state != IDLE;
  assign add_iss       = state == ADD_ISS;
  assign shf_iss       = state == SHF_ISS;
  assign bus.busy      = busy;
  assign bus.done      = state == DONE;
  assign bus.product   = {p, q};
  assign bus.alu_sel   = busy;
  assign bus.alu_op    = add_iss ? 4'b0011 : shf_iss ? 4'b1111 : 4'b0000;
  assign bus.alu_right = shf_iss;
  assign bus.alu_ai    = p;
  assign bus.alu_bi    = (add_iss & q[0]) ? m : 8'h00;
  assign bus.alu_ci    = shf_iss & c;
  assign bus.alu_bcd   = 1'b0;
  assign bus.alu_rdy   = rdy & (add_iss | shf_iss);
endmodule
